cordic_freq_ctrl: RTL and testbench
===================================

# cordic_freq_ctrl

Frequency-word controller for a bank of NUM_RX cordic NCO/mixer instances. Host-side writes land in per-channel shadow registers. A commit transfers all pending shadows to the active frequency words in the same clock edge, so multi-channel retunes are phase-coherent. The block then tracks the cordic pipeline latency and flags when mixer output reflects the new frequencies. It sits between the host command decoder and the `frequency` inputs of the cordic instances.

## Interface
Parameters:
- NUM_RX, 4: number of cordic channels (1..8).
- WF, 32: frequency word width; matches the cordic `frequency` input.
- PIPE_LAT, 18: cordic input-to-output latency in clocks (stage 0 + 16 stages + output rounding register).
- CW, 3: channel index width; must satisfy 2^CW ≥ NUM_RX.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  frequency write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready at a clock edge.
- wr_chan  in  CW  target channel.
- wr_freq  in  WF  signed frequency word.
- commit  in  1  single-cycle request to apply pending shadows.
- freq_out  out  NUM_RX*WF  active words; channel k occupies [k*WF +: WF]; drives cordic `frequency`.
- freq_upd  out  NUM_RX  one-cycle strobe per channel whose active word changed.
- pending  out  NUM_RX  shadow written, not yet committed.
- busy  out  1  commit in progress (LOAD or SETTLE).
- settled  out  1  one-cycle pulse: cordic outputs now reflect the committed words.
- err  out  1  sticky; a write targeted channel ≥ NUM_RX.

## Operation
- **State machine**: IDLE, LOAD, SETTLE.
- **IDLE**:
  - commit, or a queued commit, → LOAD.
- **LOAD** (exactly 1 cycle):
  - For each k with pending[k]=1: active[k] ← shadow[k] and freq_upd[k] ← 1.
  - Clear pending; load the settle counter with PIPE_LAT-1; → SETTLE.
  - Channels without a pending bit keep their word, and their freq_upd stays 0.
- **SETTLE**:
  - The counter decrements each cycle.
  - At 0: settled=1 for one cycle, → IDLE.
- **Writes**:
  - wr_ready = (state != LOAD).
  - An accepted write with wr_chan < NUM_RX sets shadow[wr_chan] ← wr_freq and pending[wr_chan] ← 1.
  - With wr_chan ≥ NUM_RX, the write is accepted, dropped, and err ← 1.
  - A repeated write to the same channel before commit overwrites the shadow (last value wins).
- **Simultaneous write + commit in IDLE**: the write is included in that commit, because LOAD reads the shadow on the following cycle.
- **Commit while busy**:
  - Sets a single queued flag; multiple commits collapse into one.
  - Writes accepted during SETTLE only set pending; they are applied by the queued commit, or wait for the next commit.
  - On leaving SETTLE with the flag set: → LOAD directly, clear the flag; settled still pulses that cycle.
- **Commit with no pending bits**: still runs LOAD/SETTLE; no freq_upd; settled pulses.
- **Reset values**:
  - freq_out, shadows, pending, freq_upd, busy, settled, err, queued flag = 0.
  - State = IDLE, so wr_ready = 1.
- **Reset mid-operation**: async reset_n low aborts any state immediately; no partial channel update survives.
- **Arithmetic**: frequency words are passed unmodified; signed two's-complement; no saturation.

## Timing
- Commit sampled at edge E0 → LOAD during cycle E0..E1.
- freq_out/freq_upd update at E1.
- settled is high during cycle E(1+PIPE_LAT)..E(2+PIPE_LAT); busy falls at E(2+PIPE_LAT).
- busy is registered; high from E0 through the last SETTLE cycle.
- Back-to-back commits: minimum spacing between LOADs is PIPE_LAT+1 cycles.
- Write-to-pending latency: 1 edge. Throughput: 1 write/clock except during LOAD.

## Configuration
- Macro: CORDIC_FREQ_AUTO_COMMIT_EN.
- **Defined**: every accepted in-range write generates an internal commit in the same cycle; the commit input still functions and ORs with it. Per-write retune, no host commit needed.
- **Undefined**: only the commit input starts LOAD.

## Test plan
- **Reset**: reset_n low mid-SETTLE → all outputs 0, wr_ready=1, state IDLE within the same cycle as the assertion.
- **Coherent retune**: write ch0=0x0A3D70A4, ch2=0x147AE148, then commit → at E1 both words change together; freq_upd=4'b0101; ch1 and ch3 unchanged; settled pulses 18 cycles after LOAD.
- **Same-cycle write+commit**: in IDLE, wr ch1=0x7FFFFFFF with commit → ch1 updated at E1; pending=0.
- **Commit during SETTLE**: commit at SETTLE count 5 after writing ch3=0x80000000 → second LOAD immediately follows settled; ch3 applied; exactly one extra LOAD for three extra commit pulses.
- **Out-of-range channel**: NUM_RX=4, wr_chan=5 → wr_ready=1, no shadow change, err=1 until reset.
- **Auto-commit** (macro defined): single write ch0=0x00000001 → LOAD next cycle with no commit pulse; freq_upd[0]=1.

Source files
------------

// File: rtl/cordic_freq_ctrl.sv
// Shadow/active frequency-word bank for NUM_RX cordic NCOs with phase-coherent commit and settle tracking.
// Optional feature: define CORDIC_FREQ_AUTO_COMMIT_EN so every accepted in-range write commits itself.
module cordic_freq_ctrl #(
  parameter int NUM_RX   = 4,
  parameter int WF       = 32,
  parameter int PIPE_LAT = 18,
  parameter int CW       = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [CW-1:0]        wr_chan,
  input  logic [WF-1:0]        wr_freq,
  input  logic                 commit,
  output logic [NUM_RX*WF-1:0] freq_out,
  output logic [NUM_RX-1:0]    freq_upd,
  output logic [NUM_RX-1:0]    pending,
  output logic                 busy,
  output logic                 settled,
  output logic                 err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam int         CNT_W    = $clog2(PIPE_LAT + 1);

  logic [1:0]                   r_state;
  logic [1:0]                   w_state_nxt;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_queued;
  logic                         r_busy;
  logic                         r_settled;
  logic                         r_err;
  logic [NUM_RX-1:0][WF-1:0]    r_shadow;
  logic [NUM_RX-1:0][WF-1:0]    r_active;
  logic [NUM_RX-1:0]            r_pending;
  logic [NUM_RX-1:0]            r_upd;

  logic w_wr_acc;
  logic w_in_range;
  logic w_commit;
  logic w_settle_done;
  logic w_go_load;

  assign wr_ready      = (r_state != S_LOAD);
  assign w_wr_acc      = wr_valid && wr_ready;
  assign w_in_range    = ({1'b0, wr_chan} < (CW + 1)'(NUM_RX));
`ifdef CORDIC_FREQ_AUTO_COMMIT_EN
  assign w_commit      = commit || (w_wr_acc && w_in_range);
`else
  assign w_commit      = commit;
`endif
  assign w_settle_done = (r_state == S_SETTLE) && (r_cnt == '0);
  // A commit arriving on the final SETTLE cycle chains straight into LOAD like a queued one.
  assign w_go_load     = ((r_state == S_IDLE) || w_settle_done) && (w_commit || r_queued);

  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_go_load) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_settle_done) w_state_nxt = w_go_load ? S_LOAD : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_queued  <= 1'b0;
      r_busy    <= 1'b0;
      r_settled <= 1'b0;
      r_err     <= 1'b0;
      r_upd     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nxt;
      r_busy    <= (r_state != S_IDLE) || w_go_load;
      r_settled <= w_settle_done;
      r_upd     <= (r_state == S_LOAD) ? r_pending : '0;
      if (r_state == S_LOAD) begin
        r_cnt <= CNT_W'(PIPE_LAT - 1);
      end else if ((r_state == S_SETTLE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_go_load) begin
        r_queued <= 1'b0;
      end else if (w_commit && (r_state != S_IDLE)) begin
        r_queued <= 1'b1;
      end
      if (w_wr_acc && !w_in_range) begin
        r_err <= 1'b1;
      end
    end
  end

  // NOTE: shadows and active words are reset so a retune never exposes stale words after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= '0;
    end else begin
      for (int k = 0; k < NUM_RX; k++) begin
        if (r_state == S_LOAD) begin
          if (r_pending[k]) r_active[k] <= r_shadow[k];
          r_pending[k] <= 1'b0;
        end else if (w_wr_acc && w_in_range && (wr_chan == CW'(k))) begin
          r_shadow[k]  <= wr_freq;
          r_pending[k] <= 1'b1;
        end
      end
    end
  end

  assign freq_out = r_active;
  assign freq_upd = r_upd;
  assign pending  = r_pending;
  assign busy     = r_busy;
  assign settled  = r_settled;
  assign err      = r_err;

endmodule

// File: tb/tb_cordic_freq_ctrl.sv
// Self-checking bench for cordic_freq_ctrl: directed scenarios plus random traffic against a
// timeline model (LOAD start edge + settle window) of the controller.
module tb_cordic_freq_ctrl;

  localparam int NUM_RX   = 4;
  localparam int WF       = 32;
  localparam int PIPE_LAT = 18;
  localparam int CW       = 3;
  localparam int OW       = NUM_RX * WF + 2 * NUM_RX + 4;

  logic                 clock    = 1'b0;
  logic                 reset_n  = 1'b0;
  logic                 wr_valid = 1'b0;
  logic                 commit   = 1'b0;
  logic [CW-1:0]        wr_chan  = '0;
  logic [WF-1:0]        wr_freq  = '0;
  logic                 wr_ready;
  logic [NUM_RX*WF-1:0] freq_out;
  logic [NUM_RX-1:0]    freq_upd;
  logic [NUM_RX-1:0]    pending;
  logic                 busy;
  logic                 settled;
  logic                 err;

  cordic_freq_ctrl #(.NUM_RX(NUM_RX), .WF(WF), .PIPE_LAT(PIPE_LAT), .CW(CW)) dut (
    .clock(clock), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_chan(wr_chan), .wr_freq(wr_freq), .commit(commit), .freq_out(freq_out),
    .freq_upd(freq_upd), .pending(pending), .busy(busy), .settled(settled), .err(err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: state is implied by the edge index of the most recent LOAD start.
  logic [WF-1:0]     m_active [NUM_RX];
  logic [WF-1:0]     m_shadow [NUM_RX];
  logic [NUM_RX-1:0] m_pending, m_upd;
  bit                m_busy, m_settled, m_err, m_ready, m_queued;
  int                m_cyc, m_last_load;

  wire [OW-1:0] dut_vec = {freq_out, freq_upd, pending, busy, settled, err, wr_ready};

  task automatic model_reset();
    for (int k = 0; k < NUM_RX; k++) begin
      m_active[k] = '0;
      m_shadow[k] = '0;
    end
    m_pending = '0; m_upd = '0;
    m_busy = 0; m_settled = 0; m_err = 0; m_ready = 1; m_queued = 0;
    m_cyc = 0; m_last_load = -1000;
  endtask

  task automatic model_edge();
    int d;
    bit was_load, was_idle, fin, acc, inr, ce;
    d        = m_cyc - m_last_load;
    was_load = (d == 1);
    fin      = (d == PIPE_LAT + 1);
    was_idle = (d < 1) || (d > PIPE_LAT + 1);
    acc      = wr_valid && !was_load;
    inr      = (int'(wr_chan) < NUM_RX);
`ifdef CORDIC_FREQ_AUTO_COMMIT_EN
    ce = commit || (acc && inr);
`else
    ce = commit;
`endif
    m_upd = '0;
    if (was_load) begin
      for (int k = 0; k < NUM_RX; k++)
        if (m_pending[k]) begin
          m_active[k] = m_shadow[k];
          m_upd[k]    = 1'b1;
        end
      m_pending = '0;
    end
    if (acc) begin
      if (inr) begin
        m_shadow[wr_chan]  = wr_freq;
        m_pending[wr_chan] = 1'b1;
      end else begin
        m_err = 1;
      end
    end
    m_settled = fin;
    if ((was_idle || fin) && (ce || m_queued)) begin
      m_last_load = m_cyc;
      m_queued    = 0;
    end else if (ce && !was_idle) begin
      m_queued = 1;
    end
    m_busy  = ((m_cyc - m_last_load) >= 0) && ((m_cyc - m_last_load) <= PIPE_LAT + 1);
    m_cyc++;
    m_ready = !((m_cyc - m_last_load) == 1);
  endtask

  function automatic logic [OW-1:0] exp_vec();
    logic [NUM_RX*WF-1:0] f;
    for (int k = 0; k < NUM_RX; k++) f[k*WF +: WF] = m_active[k];
    return {f, m_upd, m_pending, m_busy, m_settled, m_err, m_ready};
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) step();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL wait_idle: busy still %b after 100 cycles", busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== {(OW-1)'(0), 1'b1}) $display("FAIL reset_values: got %h want %h", dut_vec, {(OW-1)'(0), 1'b1});
    else n_pass++;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();
    step();
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_release: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_coherent_retune();
    int n;
    wr_valid = 1; wr_chan = 3'd0; wr_freq = 32'h0A3D70A4; step();
    wr_chan = 3'd2; wr_freq = 32'h147AE148; step();
    wr_valid = 0;
`ifndef CORDIC_FREQ_AUTO_COMMIT_EN
    n_checks++;
    if (pending !== 4'b0101) $display("FAIL coh_pending: got %b want 0101", pending);
    else n_pass++;
`endif
    commit = 1; step(); commit = 0;
    n_checks++;
    if (wr_ready !== 1'b0 || busy !== 1'b1) $display("FAIL coh_load: wr_ready %b busy %b want 0 1", wr_ready, busy);
    else n_pass++;
    step();
`ifndef CORDIC_FREQ_AUTO_COMMIT_EN
    n_checks++;
    if (freq_out !== {32'h0, 32'h147AE148, 32'h0, 32'h0A3D70A4} || freq_upd !== 4'b0101)
      $display("FAIL coh_words: got %h upd %b want 00000000147ae148000000000a3d70a4 upd 0101", freq_out, freq_upd);
    else n_pass++;
`endif
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL coh_model: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
    n = 0;
    for (int i = 0; i < 40 && !settled; i++) begin
      step();
      n++;
    end
    n_checks++;
    if (n !== PIPE_LAT || settled !== 1'b1) $display("FAIL coh_settle_lat: got %0d want %0d", n, PIPE_LAT);
    else n_pass++;
    step();
    n_checks++;
    if (busy !== 1'b0 || settled !== 1'b0) $display("FAIL coh_busy_fall: busy %b settled %b want 0 0", busy, settled);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    wait_idle();
    wr_valid = 1; wr_chan = 3'd1; wr_freq = 32'h7FFFFFFF; commit = 1;
    step();
    wr_valid = 0; commit = 0;
    step();
    n_checks++;
    if (freq_out[WF +: WF] !== 32'h7FFFFFFF || pending !== 4'b0000 || freq_upd !== 4'b0010)
      $display("FAIL same_cycle: ch1 %h pending %b upd %b want 7fffffff 0000 0010", freq_out[WF +: WF], pending, freq_upd);
    else n_pass++;
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL same_cycle_model: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_commit_settle();
    int loads, load_idx, set_idx;
    wait_idle();
    commit = 1; step(); commit = 0;
    step();
    n_checks++;
    if (freq_upd !== 4'b0000) $display("FAIL empty_commit_upd: got %b want 0000", freq_upd);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        wr_valid = 1; wr_chan = 3'd3; wr_freq = 32'h80000000;
      end
      step();
      wr_valid = 0;
    end
    for (int p = 0; p < 3; p++) begin
      commit = 1; step(); commit = 0;
      if (p < 2) step();
    end
    loads = 0; load_idx = -1; set_idx = -1;
    for (int i = 0; i < 45; i++) begin
      step();
      if (!wr_ready) begin
        loads++;
        if (load_idx < 0) load_idx = i;
      end
      if (settled && set_idx < 0) set_idx = i;
    end
    n_checks++;
    if (loads !== 1) $display("FAIL queued_load_count: got %0d want 1", loads);
    else n_pass++;
    n_checks++;
    if (set_idx < 0 || load_idx !== set_idx) $display("FAIL queued_follows_settled: load at %0d settled at %0d", load_idx, set_idx);
    else n_pass++;
    n_checks++;
    if (freq_out[3*WF +: WF] !== 32'h80000000 || busy !== 1'b0)
      $display("FAIL queued_ch3: got %h busy %b want 80000000 0", freq_out[3*WF +: WF], busy);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    wait_idle();
    n_checks++;
    if (wr_ready !== 1'b1 || err !== 1'b0) $display("FAIL oor_pre: wr_ready %b err %b want 1 0", wr_ready, err);
    else n_pass++;
    wr_valid = 1; wr_chan = 3'd5; wr_freq = $urandom;
    step();
    wr_valid = 0;
    n_checks++;
    if (err !== 1'b1 || pending !== 4'b0000 || busy !== 1'b0)
      $display("FAIL oor_drop: err %b pending %b busy %b want 1 0000 0", err, pending, busy);
    else n_pass++;
    repeat (3) step();
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL oor_sticky: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_auto_commit();
    wait_idle();
    wr_valid = 1; wr_chan = 3'd0; wr_freq = 32'h00000001;
    step();
    wr_valid = 0;
`ifdef CORDIC_FREQ_AUTO_COMMIT_EN
    n_checks++;
    if (wr_ready !== 1'b0) $display("FAIL auto_load: wr_ready %b want 0", wr_ready);
    else n_pass++;
    step();
    n_checks++;
    if (freq_upd[0] !== 1'b1 || freq_out[0 +: WF] !== 32'h00000001)
      $display("FAIL auto_upd: upd %b ch0 %h want 1 00000001", freq_upd[0], freq_out[0 +: WF]);
    else n_pass++;
`else
    n_checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b0 || pending[0] !== 1'b1)
      $display("FAIL no_auto: wr_ready %b busy %b pending0 %b want 1 0 1", wr_ready, busy, pending[0]);
    else n_pass++;
    commit = 1; step(); commit = 0;
`endif
    wait_idle();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 800; i++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_chan  = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(4, 7)) : CW'($urandom_range(0, 3));
      wr_freq  = $urandom;
      commit   = ($urandom_range(0, 15) == 0);
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        if (bad < 10) $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec());
        bad++;
      end else n_pass++;
    end
    wr_valid = 0; commit = 0;
    wait_idle();
  endtask

  task automatic test_reset_mid_settle();
    wr_valid = 1; wr_chan = 3'd2; wr_freq = $urandom; commit = 1;
    step();
    wr_valid = 0; commit = 0;
    repeat (8) step();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== {(OW-1)'(0), 1'b1}) $display("FAIL reset_mid_settle: got %h want %h", dut_vec, {(OW-1)'(0), 1'b1});
    else n_pass++;
    @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();
    repeat (2) step();
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_mid_release: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_coherent_retune();
    test_same_cycle();
    test_commit_settle();
    test_out_of_range();
    test_auto_commit();
    test_random();
    test_reset_mid_settle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
